// File: rtl/regfile_pkg.sv
// Shared register-file definitions.
// Holds the register-file geometry, which is 32 entries of 64 bits.
// Index 31 is hard-wired to read as zero.
// Also holds the state type of the read-port arbiter.
package regfile_pkg;

    localparam int REG_COUNT  = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 64;
    localparam int ZERO_REG   = 31;

    // IDLE: the response register is empty.
    // RESP: a response is waiting for the consumer.
    typedef enum logic {
        IDLE,
        RESP
    } rd_arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority picker.
// This block is purely combinational.
// It scans the request vector starting at ptr and moving upward, wrapping around.
// The first set bit it finds is the winner.
// Ports:
//   req        in   NUM_REQ  request bits
//   ptr        in   IDX_W    index that has the highest priority this cycle
//   grant      out  NUM_REQ  one-hot winner (all zero when there is no request)
//   grant_idx  out  IDX_W    binary index of the winner
//   grant_any  out  1        at least one request is present
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    // The outer loop walks priority offsets from ptr.
    // The inner loop matches each offset to a requester index.
    // Because of this, every bit-select uses a constant index.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_any && req[i] && (((int'(ptr) + k) % NUM_REQ) == i)) begin
                    grant_any = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Register-file read-port arbiter.
// NUM_REQ requesters share the single read port of the register file.
// Arbitration is round-robin, with at most one grant per cycle.
// The read value is captured in a one-entry response register.
// It is held there until the consumer accepts it.
// Ports:
//   clk           in   1                   clock, rising edge
//   reset         in   1                   synchronous, active-high
//   req_valid     in   NUM_REQ             request pending per requester
//   req_addr      in   NUM_REQ*ADDR_WIDTH  register index, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_ready     out  NUM_REQ             one-hot grant
//   rf_read_sel   out  ADDR_WIDTH          select to the register-file read mux
//   rf_read_data  in   DATA_WIDTH          combinational read-mux output
//   rsp_valid     out  1                   response register holds data
//   rsp_id        out  $clog2(NUM_REQ)     requester that owns the response
//   rsp_data      out  DATA_WIDTH          read value
//   rsp_ready     in   1                   consumer accepts the response
module regfile_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 31,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]         rf_read_sel,
    input  logic [DATA_WIDTH-1:0]         rf_read_data,
    output logic                          rsp_valid,
    output logic [ID_W-1:0]               rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    input  logic                          rsp_ready
);

    import regfile_pkg::*;

    rd_arb_state_t         state;
    rd_arb_state_t         state_next;
    logic [ID_W-1:0]       rr_ptr;
    logic [NUM_REQ-1:0]    pick_grant;
    logic [ID_W-1:0]       pick_idx;
    logic                  pick_any;
    logic                  can_issue;
    logic                  grant_fire;
    logic [ADDR_WIDTH-1:0] win_addr;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_pick (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .grant_any (pick_any)
    );

    // Route the winner's address to the read port.
    // The one-hot grant is used as the mux select.
    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // A new read is issued only if the response register will be free at the next edge.
    // Reset masks grants combinationally.
    // This means no partial grant can leak out while reset is high.
    assign can_issue   = (state == IDLE) || (state == RESP && rsp_ready);
    assign grant_fire  = !reset && can_issue && pick_any;
    assign req_ready   = grant_fire ? pick_grant : '0;
    assign rf_read_sel = grant_fire ? win_addr : '0;
    assign rsp_valid   = (state == RESP);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // A grant always leaves the FSM in RESP, even when it replaces an accepted response.
    // Acceptance without a new grant empties the response register.
    always_comb begin
        state_next = state;
        if (grant_fire) begin
            state_next = RESP;
        end else if (state == RESP && rsp_ready) begin
            state_next = IDLE;
        end
    end

    // Response register and round-robin pointer.
    // Both update only on grant edges.
    // Under backpressure they hold their values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
        end else if (grant_fire) begin
            rsp_data <= (win_addr == ADDR_WIDTH'(ZERO_REG)) ? '0 : rf_read_data;
            rsp_id   <= pick_idx;
            rr_ptr   <= (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Testbench for regfile_read_arbiter.
// The bench runs a directed sequence first, then a randomized phase.
// A behavioural model of the arbiter is kept here.
// It tracks the round-robin pointer and the one-entry response register as plain integers.
module tb_regfile_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam logic [DW-1:0] DEAD = 64'hDEADBEEF_CAFEF00D;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]  req_ready;
    logic [AW-1:0] rf_read_sel;
    logic [DW-1:0] rf_read_data;
    logic          rsp_valid;
    logic [1:0]    rsp_id;
    logic [DW-1:0] rsp_data;
    logic          rsp_ready;

    logic          force_dead;
    logic [DW-1:0] rf_model [32];

    int            vectors = 0;
    int            miscompares = 0;
    int            m_ptr = 0;
    bit            m_valid = 1'b0;
    int            m_id = 0;
    logic [DW-1:0] m_data = '0;
    int            last_win = -1;

    localparam logic [N*AW-1:0] A_RR = {5'd20, 5'd12, 5'd7, 5'd3};

    // Free-running clock.
    always #5 clk = ~clk;

    // The register file is modelled as a combinational read mux.
    // It can be overridden with a fixed pattern.
    assign rf_read_data = force_dead ? DEAD : rf_model[rf_read_sel];

    regfile_read_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .rf_read_sel  (rf_read_sel),
        .rf_read_data (rf_read_data),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .rsp_ready    (rsp_ready)
    );

    function automatic logic [AW-1:0] addrOf(input logic [N*AW-1:0] a, input int i);
        return AW'(a >> (i * AW));
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [N-1:0] v,
                                 input logic [N*AW-1:0] a, input logic rr);
        reset     = rst;
        req_valid = v;
        req_addr  = a;
        rsp_ready = rr;
    endtask

    // This task runs one clock cycle.
    // First it predicts and checks the grant and the read select.
    // Then it clocks the design and advances the model.
    // Finally it checks the response register.
    task automatic runCycle();
        int            win;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        #1;
        win = -1;
        if (!reset && (!m_valid || rsp_ready)) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (win < 0 && ((req_valid >> c) & 1) != 0) win = c;
            end
        end
        waddr = (win >= 0) ? addrOf(req_addr, win) : '0;
        checkOutput("req_ready", 64'(req_ready), (win >= 0) ? (64'd1 << win) : 64'd0);
        checkOutput("rf_read_sel", 64'(rf_read_sel), 64'(waddr));
        wdata = (waddr == 5'd31) ? '0 : (force_dead ? DEAD : rf_model[waddr]);
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0;
            m_id    = 0;
            m_data  = '0;
            m_ptr   = 0;
        end else if (win >= 0) begin
            m_valid = 1'b1;
            m_id    = win;
            m_data  = wdata;
            m_ptr   = (win + 1) % N;
        end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
        end
        last_win = win;
        #1;
        checkOutput("rsp_valid", 64'(rsp_valid), 64'(m_valid));
        checkOutput("rsp_id", 64'(rsp_id), 64'(m_id));
        checkOutput("rsp_data", rsp_data, m_data);
        @(negedge clk);
    endtask

    // The stimulus is a linear sequence: directed scenarios, then random traffic.
    initial begin
        logic [N-1:0]    pv;
        logic [N*AW-1:0] pa;

        for (int r = 0; r < 32; r++) rf_model[r] = {$urandom, $urandom};
        force_dead = 1'b0;

        $display("[TB] reset held with all requesters valid");
        applyStimulus(1'b1, 4'b1111, A_RR, 1'b1);
        runCycle();
        runCycle();

        $display("[TB] round-robin over addresses 3/7/12/20");
        applyStimulus(1'b0, 4'b1111, A_RR, 1'b1);
        for (int s = 0; s < 6; s++) runCycle();

        $display("[TB] backpressure with a single request to x5");
        applyStimulus(1'b0, 4'b0000, A_RR, 1'b1);
        runCycle();
        applyStimulus(1'b0, 4'b0001, {A_RR[19:5], 5'd5}, 1'b0);
        runCycle();
        applyStimulus(1'b0, 4'b1110, A_RR, 1'b0);
        for (int s = 0; s < 4; s++) runCycle();
        applyStimulus(1'b0, 4'b1110, A_RR, 1'b1);
        runCycle();
        applyStimulus(1'b0, 4'b0000, A_RR, 1'b1);
        runCycle();

        $display("[TB] zero register against a fixed read pattern");
        force_dead = 1'b1;
        applyStimulus(1'b0, 4'b1111, {5'd31, 5'd4, 5'd31, 5'd31}, 1'b1);
        for (int s = 0; s < 4; s++) runCycle();
        force_dead = 1'b0;
        applyStimulus(1'b0, 4'b0000, A_RR, 1'b1);
        runCycle();

        $display("[TB] pointer wrap from requester 3 to requester 0");
        applyStimulus(1'b0, 4'b0100, A_RR, 1'b1);
        runCycle();
        applyStimulus(1'b0, 4'b1001, A_RR, 1'b1);
        runCycle();
        applyStimulus(1'b0, 4'b0001, A_RR, 1'b1);
        runCycle();
        applyStimulus(1'b0, 4'b0011, A_RR, 1'b1);
        runCycle();
        applyStimulus(1'b0, 4'b0000, A_RR, 1'b1);
        runCycle();

        $display("[TB] reset while a response is stalled");
        applyStimulus(1'b0, 4'b0100, A_RR, 1'b0);
        runCycle();
        applyStimulus(1'b0, 4'b1011, A_RR, 1'b0);
        runCycle();
        applyStimulus(1'b1, 4'b1011, A_RR, 1'b0);
        runCycle();
        applyStimulus(1'b0, 4'b1111, A_RR, 1'b1);
        runCycle();
        applyStimulus(1'b0, 4'b0000, A_RR, 1'b1);
        runCycle();

        $display("[TB] random traffic");
        pv = '0;
        pa = '0;
        for (int s = 0; s < 400; s++) begin
            for (int i = 0; i < N; i++) begin
                if (((pv >> i) & 1) == 0 && $urandom_range(0, 1) == 1) begin
                    pv = pv | (N'(1) << i);
                    pa = (pa & ~((N*AW)'(5'h1F) << (i * AW)))
                       | ((N*AW)'($urandom_range(0, 31)) << (i * AW));
                end
            end
            applyStimulus($urandom_range(0, 49) == 0, pv, pa, $urandom_range(0, 3) != 0);
            runCycle();
            if (last_win >= 0) pv = pv & ~(N'(1) << last_win);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
